// File: rtl/roi_shift_word.sv
// roi_shift_word: NCH-channel serial-to-parallel word assembler with a
// matching parallel-to-serial return path. Every strobe consumes one bit per
// channel; after WIDTH strobes the assembled words are published on `word`,
// reloaded into the output shifters, and counted. The serial output is
// therefore the input stream delayed by exactly WIDTH strobes.
//
// The serial output port is named sdo because "do" is a reserved word.
module roi_shift_word #(
  parameter int WIDTH     = 8,
  parameter int NCH       = 1,
  parameter int LSB_FIRST = 1,
  parameter int COUNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stb,
  input  logic                   clr,
  input  logic [NCH-1:0]         di,
  output logic [NCH-1:0]         sdo,
  output logic [NCH*WIDTH-1:0]   word,
  output logic                   word_valid,
  output logic [COUNT_W-1:0]     word_count
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0]             bit_cnt;
  logic [NCH-1:0][WIDTH-1:0]    in_sr;
  logic [NCH-1:0][WIDTH-1:0]    out_sr;
  logic [NCH-1:0][WIDTH-1:0]    in_next;
  logic [NCH-1:0][WIDTH-1:0]    out_next;
  logic                         last_bit;

  assign last_bit = (bit_cnt == LAST_BIT);

  // Next shift values: input shifter takes di at the far end so the first bit
  // lands at bit 0 (LSB first) or bit WIDTH-1 (MSB first) after WIDTH shifts;
  // output shifter moves toward its output end, back-filling with zero.
  always_comb begin
    in_next  = '0;
    out_next = '0;
    for (int c = 0; c < NCH; c++) begin
      if (LSB_FIRST != 0) begin
        in_next[c]  = {di[c], in_sr[c][WIDTH-1:1]};
        out_next[c] = {1'b0, out_sr[c][WIDTH-1:1]};
      end else begin
        in_next[c]  = {in_sr[c][WIDTH-2:0], di[c]};
        out_next[c] = {out_sr[c][WIDTH-2:0], 1'b0};
      end
    end
  end

  // Serial output is taken straight from the output shifter's output end.
  always_comb begin
    sdo = '0;
    for (int c = 0; c < NCH; c++) begin
      if (LSB_FIRST != 0) begin
        sdo[c] = out_sr[c][0];
      end else begin
        sdo[c] = out_sr[c][WIDTH-1];
      end
    end
  end

  // Bit counter, shifters, published word and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      in_sr      <= '0;
      out_sr     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      word_count <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        // Discard only the partial word; the return path keeps shifting
        // whatever it already holds on later strobes.
        bit_cnt <= '0;
        in_sr   <= '0;
      end else if (stb) begin
        if (last_bit) begin
          word       <= in_next;
          out_sr     <= in_next;
          in_sr      <= '0;
          bit_cnt    <= '0;
          word_valid <= 1'b1;
          word_count <= word_count + COUNT_W'(1);
        end else begin
          in_sr   <= in_next;
          out_sr  <= out_next;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_roi_shift_word.sv
// Directed bench for roi_shift_word: a vector table for continuous and gapped
// two-channel words, plus hand-written sequences for clear, async reset,
// counter wrap and MSB-first ordering.
module tb_roi_shift_word;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        stb_a = 1'b0;
  logic        clr_a = 1'b0;
  logic [1:0]  di_a = 2'b00;
  logic [1:0]  do_a;
  logic [15:0] word_a;
  logic        valid_a;
  logic [15:0] cnt_a;

  logic [0:0]  do_c;
  logic [7:0]  word_c;
  logic        valid_c;
  logic [1:0]  cnt_c;

  logic        stb_b = 1'b0;
  logic        clr_b = 1'b0;
  logic [0:0]  di_b = 1'b0;
  logic [0:0]  do_b;
  logic [7:0]  word_b;
  logic        valid_b;
  logic [15:0] cnt_b;

  int checks = 0;
  int errors = 0;

  roi_shift_word #(.WIDTH(8), .NCH(2), .LSB_FIRST(1), .COUNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .stb(stb_a), .clr(clr_a), .di(di_a),
    .sdo(do_a), .word(word_a), .word_valid(valid_a), .word_count(cnt_a));

  roi_shift_word #(.WIDTH(8), .NCH(1), .LSB_FIRST(1), .COUNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .stb(stb_a), .clr(clr_a), .di(di_a[0]),
    .sdo(do_c), .word(word_c), .word_valid(valid_c), .word_count(cnt_c));

  roi_shift_word #(.WIDTH(8), .NCH(1), .LSB_FIRST(0), .COUNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .stb(stb_b), .clr(clr_b), .di(di_b),
    .sdo(do_b), .word(word_b), .word_valid(valid_b), .word_count(cnt_b));

  always #5 clk = ~clk;

  typedef struct {
    logic        stb;
    logic        clr;
    logic [1:0]  di;
    logic        ev;
    logic [15:0] ew;
    logic [15:0] ec;
    logic [1:0]  edo;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic s, input logic [1:0] d, input logic ev,
                      input logic [15:0] ew, input logic [15:0] ec, input logic [1:0] edo);
    vec_t v;
    v.stb = s; v.clr = 1'b0; v.di = d; v.ev = ev; v.ew = ew; v.ec = ec; v.edo = edo;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] gap_pat;
    logic [7:0] msb_a;
    logic [7:0] msb_f;
    logic [1:0] cur_do;

    d0 = 8'hA5;
    d1 = 8'h3C;
    gap_pat = 8'b1010_0110;
    msb_a = 8'hA5;
    msb_f = 8'h0F;

    // First word, continuous strobes.
    for (int i = 0; i < 8; i++)
      push(1'b1, {d1[i], d0[i]}, (i == 7), (i == 7) ? 16'h3CA5 : 16'h0000,
           (i == 7) ? 16'd1 : 16'd0, (i == 7) ? 2'b01 : 2'b00);
    push(1'b0, 2'b11, 1'b0, 16'h3CA5, 16'd1, 2'b01);
    // Second word, same data with gaps; return path replays the first word.
    cur_do = 2'b01;
    for (int i = 0; i < 8; i++) begin
      if (gap_pat[i]) push(1'b0, 2'b10, 1'b0, 16'h3CA5, 16'd1, cur_do);
      if (i < 7) begin
        cur_do = {d1[i+1], d0[i+1]};
        push(1'b1, {d1[i], d0[i]}, 1'b0, 16'h3CA5, 16'd1, cur_do);
      end else begin
        cur_do = 2'b01;
        push(1'b1, {d1[i], d0[i]}, 1'b1, 16'h3CA5, 16'd2, cur_do);
      end
    end
    push(1'b0, 2'b00, 1'b0, 16'h3CA5, 16'd2, 2'b01);

    // Initial reset.
    #12;
    chk("init_word", word_a, 16'h0);
    chk("init_valid", valid_a, 1'b0);
    chk("init_do", do_a, 2'b00);
    rst_n = 1'b1;
    tick();

    foreach (tbl[k]) begin
      stb_a = tbl[k].stb;
      clr_a = tbl[k].clr;
      di_a  = tbl[k].di;
      tick();
      chk($sformatf("vec%0d_valid", k), valid_a, tbl[k].ev);
      chk($sformatf("vec%0d_word", k), word_a, tbl[k].ew);
      chk($sformatf("vec%0d_count", k), cnt_a, tbl[k].ec);
      chk($sformatf("vec%0d_do", k), do_a, tbl[k].edo);
    end
    chk("c_word_after_tbl", word_c, 8'hA5);
    chk("c_count_after_tbl", cnt_c, 2'd2);

    // Asynchronous reset between edges clears outputs before the next edge.
    stb_a = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_word", word_a, 16'h0);
    chk("arst_count", cnt_a, 16'h0);
    chk("arst_do", do_a, 2'b00);
    chk("arst_valid", valid_a, 1'b0);
    chk("arst_c_word", word_c, 8'h0);
    #1 rst_n = 1'b1;
    tick();

    // Partial word discarded by clr.
    stb_a = 1'b1;
    di_a = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("clr_pre%0d_valid", i), valid_a, 1'b0);
    end
    clr_a = 1'b1;
    di_a = 2'b01;
    tick();
    chk("clr_edge_valid", valid_a, 1'b0);
    chk("clr_edge_count", cnt_a, 16'd0);
    clr_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("clr_post%0d_valid", i), valid_a, (i == 7));
    end
    chk("clr_word", word_a, 16'h00FF);
    chk("clr_count", cnt_a, 16'd1);
    stb_a = 1'b0;
    tick();
    chk("clr_valid_drop", valid_a, 1'b0);
    chk("clr_word_hold", word_a, 16'h00FF);

    // Serial replay and counter wrap.
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    stb_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      di_a = {1'b0, d0[i]};
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("replay%0d_do", i), do_a[0], d0[i]);
      di_a = 2'b00;
      tick();
    end
    chk("replay_word", word_a, 16'h0000);
    chk("replay_do_after", do_a[0], 1'b0);
    di_a = 2'b01;
    for (int i = 0; i < 24; i++) tick();
    stb_a = 1'b0;
    chk("wrap_a_count", cnt_a, 16'd5);
    chk("wrap_c_count", cnt_c, 2'd1);
    chk("wrap_c_word", word_c, 8'hFF);
    chk("wrap_c_valid", valid_c, 1'b1);
    chk("wrap_c_do", do_c, 1'b1);
    tick();

    // MSB-first instance.
    stb_b = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      di_b = msb_a[i];
      tick();
      chk($sformatf("msb_a%0d_valid", i), valid_b, (i == 0));
    end
    chk("msb_word", word_b, 8'hA5);
    chk("msb_count", cnt_b, 16'd1);
    chk("msb_do", do_b, 1'b1);
    di_b = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stb_b = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("msb_rst_word", word_b, 8'h00);
    chk("msb_rst_count", cnt_b, 16'd0);
    chk("msb_rst_do", do_b, 1'b0);
    #1 rst_n = 1'b1;
    stb_b = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      di_b = msb_f[i];
      tick();
      chk($sformatf("msb_f%0d_valid", i), valid_b, (i == 0));
    end
    stb_b = 1'b0;
    chk("msb_f_word", word_b, 8'h0F);
    chk("msb_f_count", cnt_b, 16'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
